// File: rtl/axi_rd_burst_ctrl.sv
// AXI4 read-channel burst engine: turns one AR burst into per-beat memory reads
// and returns the captured data on the R channel through a 4-entry buffer.
module axi_rd_burst_ctrl #(
   parameter int AXI_ADDR_WIDTH = 32,
   parameter int MEM_ADDR_WIDTH = 10,
   parameter int DATA_WIDTH     = 32,
   parameter int ID_WIDTH       = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [ID_WIDTH-1:0]       s_arid,
   input  logic [AXI_ADDR_WIDTH-1:0] s_araddr,
   input  logic [7:0]                s_arlen,
   input  logic [2:0]                s_arsize,
   input  logic [1:0]                s_arburst,
   input  logic                      s_arvalid,
   output logic                      s_arready,
   output logic [ID_WIDTH-1:0]       s_rid,
   output logic [DATA_WIDTH-1:0]     s_rdata,
   output logic [1:0]                s_rresp,
   output logic                      s_rlast,
   output logic                      s_rvalid,
   input  logic                      s_rready,
   output logic                      mem_rd_en,
   output logic [MEM_ADDR_WIDTH-1:0] mem_rd_addr,
   input  logic                      mem_rd_dat_vld,
   input  logic [DATA_WIDTH-1:0]     mem_rd_dat
);
   localparam int BYTE_LSB  = $clog2(DATA_WIDTH/8);
   localparam int BUF_DEPTH = 4;

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;
   typedef enum logic [1:0] {MODE_FIXED, MODE_INCR, MODE_WRAP} mode_e;

   state_e                    state_q, state_d;
   mode_e                     mode_q, mode_d;
   logic                      arReady_q, arReady_d;
   logic [ID_WIDTH-1:0]       id_q, id_d;
   logic [7:0]                len_q, len_d;
   logic                      slvErr_q, slvErr_d;
   logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [7:0]                beat_q, beat_d;
   logic                      tagLast_q, tagLast_d;

   logic [DATA_WIDTH-1:0]     bufData_q [BUF_DEPTH];
   logic                      bufLast_q [BUF_DEPTH];
   logic                      bufErr_q  [BUF_DEPTH];
   logic [1:0]                wrPtr_q, rdPtr_q;
   logic [2:0]                count_q;

   logic                      arFire, issue, push, pop, wrapLegal;
   logic [MEM_ADDR_WIDTH-1:0] wrapMask, addrInc, addrNext;
   logic                      unusedBits;

   assign unusedBits = ^{s_arsize, s_araddr};

   assign arFire    = s_arvalid & arReady_q;
   assign s_rvalid  = (count_q != 3'd0);
   assign pop       = s_rvalid & s_rready;
   // Data returning after a reset belongs to an abandoned burst, so only capture while busy.
   assign push      = mem_rd_dat_vld & (state_q != IDLE);
   assign issue     = (state_q == ISSUE) &&
                      ((count_q + {2'b00, mem_rd_dat_vld}) < 3'(BUF_DEPTH));
   assign wrapLegal = (s_arlen == 8'd1) || (s_arlen == 8'd3) ||
                      (s_arlen == 8'd7) || (s_arlen == 8'd15);

   assign wrapMask  = MEM_ADDR_WIDTH'(len_q);
   assign addrInc   = addr_q + MEM_ADDR_WIDTH'(1);

   always_comb begin
      addrNext = addrInc;
      case (mode_q)
         MODE_FIXED: addrNext = addr_q;
         MODE_WRAP:  addrNext = (addr_q & ~wrapMask) | (addrInc & wrapMask);
         default:    addrNext = addrInc;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      mode_d    = mode_q;
      id_d      = id_q;
      len_d     = len_q;
      slvErr_d  = slvErr_q;
      addr_d    = addr_q;
      beat_d    = beat_q;
      tagLast_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (arFire) begin
               id_d     = s_arid;
               len_d    = s_arlen;
               addr_d   = s_araddr[BYTE_LSB +: MEM_ADDR_WIDTH];
               beat_d   = 8'd0;
               slvErr_d = (s_arburst == 2'b11);
               if (s_arburst == 2'b00)
                  mode_d = MODE_FIXED;
               else if ((s_arburst == 2'b10) && wrapLegal)
                  mode_d = MODE_WRAP;
               else
                  mode_d = MODE_INCR;
               state_d  = ISSUE;
            end
         end
         ISSUE: begin
            if (issue) begin
               addr_d    = addrNext;
               tagLast_d = (beat_q == len_q);
               if (beat_q == len_q)
                  state_d = DRAIN;
               else
                  beat_d = beat_q + 8'd1;
            end
         end
         DRAIN: begin
            if (pop && s_rlast)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      arReady_d = (state_d == IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         mode_q    <= MODE_INCR;
         arReady_q <= 1'b0;
         id_q      <= '0;
         len_q     <= '0;
         slvErr_q  <= 1'b0;
         addr_q    <= '0;
         beat_q    <= '0;
         tagLast_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         mode_q    <= mode_d;
         arReady_q <= arReady_d;
         id_q      <= id_d;
         len_q     <= len_d;
         slvErr_q  <= slvErr_d;
         addr_q    <= addr_d;
         beat_q    <= beat_d;
         tagLast_q <= tagLast_d;
      end
   end

   // The credit check on issue guarantees a push never finds the buffer full.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
         for (int i = 0; i < BUF_DEPTH; i++) begin
            bufData_q[i] <= '0;
            bufLast_q[i] <= 1'b0;
            bufErr_q[i]  <= 1'b0;
         end
      end else begin
         if (push) begin
            bufData_q[wrPtr_q] <= mem_rd_dat;
            bufLast_q[wrPtr_q] <= tagLast_q;
            bufErr_q[wrPtr_q]  <= slvErr_q;
            wrPtr_q            <= wrPtr_q + 2'd1;
         end
         if (pop)
            rdPtr_q <= rdPtr_q + 2'd1;
         case ({push, pop})
            2'b10:   count_q <= count_q + 3'd1;
            2'b01:   count_q <= count_q - 3'd1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign s_arready   = arReady_q;
   assign s_rid       = id_q;
   assign s_rdata     = bufData_q[rdPtr_q];
   assign s_rlast     = bufLast_q[rdPtr_q];
   assign s_rresp     = {bufErr_q[rdPtr_q], 1'b0};
   assign mem_rd_en   = issue;
   assign mem_rd_addr = addr_q;

endmodule

// File: tb/tb_axi_rd_burst_ctrl.sv
// Bench for axi_rd_burst_ctrl: a behavioural memory plus a burst-level reference
// model that predicts every address, data word, RLAST, RRESP and RID.
module tb_axi_rd_burst_ctrl;
   localparam int AW    = 32;
   localparam int MW    = 10;
   localparam int DW    = 32;
   localparam int IW    = 4;
   localparam int DEPTH = 1024;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [IW-1:0] s_arid;
   logic [AW-1:0] s_araddr;
   logic [7:0]    s_arlen;
   logic [2:0]    s_arsize;
   logic [1:0]    s_arburst;
   logic          s_arvalid;
   logic          s_arready;
   logic [IW-1:0] s_rid;
   logic [DW-1:0] s_rdata;
   logic [1:0]    s_rresp;
   logic          s_rlast;
   logic          s_rvalid;
   logic          s_rready;
   logic          mem_rd_en;
   logic [MW-1:0] mem_rd_addr;
   logic          mem_rd_dat_vld;
   logic [DW-1:0] mem_rd_dat;

   logic [DW-1:0] memArr [DEPTH];
   logic          memVldQ;
   logic [DW-1:0] memDatQ;
   logic          strayVld;

   int testsRun    = 0;
   int testsFailed = 0;

   always #5 clk = ~clk;

   axi_rd_burst_ctrl #(
      .AXI_ADDR_WIDTH(AW), .MEM_ADDR_WIDTH(MW), .DATA_WIDTH(DW), .ID_WIDTH(IW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
      .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
      .s_rvalid(s_rvalid), .s_rready(s_rready),
      .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
      .mem_rd_dat_vld(mem_rd_dat_vld), .mem_rd_dat(mem_rd_dat)
   );

   // One-cycle-latency memory; strayVld fakes a late response from an abandoned burst.
   always @(posedge clk) begin
      memVldQ <= mem_rd_en;
      memDatQ <= memArr[mem_rd_addr];
   end
   assign mem_rd_dat_vld = memVldQ | strayVld;
   assign mem_rd_dat     = memDatQ;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      testsRun++;
      assert (observed === expected) else begin
         testsFailed++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   function automatic logic [63:0] allOutputs();
      return 64'({s_arready, s_rvalid, s_rlast, s_rresp, s_rid, s_rdata, mem_rd_en, mem_rd_addr});
   endfunction

   // Runs one burst from a negedge where the DUT is idle; ends on a negedge, idle again.
   task automatic applyStimulus(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                                input logic [7:0] len, input logic [1:0] burst,
                                input int stallCycles, input bit randReady);
      int   expAddr[$];
      int   nBeats, start, base, budget, k;
      int   issued, accepted, firstValid, firstIssue, maxOut;
      bit   stalled, done, ready, wrapOk;
      logic [DW-1:0] heldData;
      nBeats = int'(len) + 1;
      start  = int'(addr >> 2) % DEPTH;
      wrapOk = (burst == 2'b10) && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
      for (int i = 0; i < nBeats; i++) begin
         if (burst == 2'b00)
            expAddr.push_back(start);
         else if (wrapOk) begin
            base = start - (start % nBeats);
            expAddr.push_back(base + ((start - base + i) % nBeats));
         end else
            expAddr.push_back((start + i) % DEPTH);
      end

      s_arid = id; s_araddr = addr; s_arlen = len; s_arburst = burst;
      s_arsize = 3'b010; s_arvalid = 1'b1; s_rready = 1'b0;
      k = 0;
      while (!s_arready && k < 20) begin
         @(negedge clk);
         k++;
      end
      checkOutput("ar_accept", s_arready, 1'b1);

      issued = 0; accepted = 0; firstValid = -1; firstIssue = -1; maxOut = 0;
      stalled = 1'b0; done = 1'b0; heldData = '0;
      budget = 60 + 6 * nBeats + stallCycles;
      for (int cyc = 1; cyc <= budget && !done; cyc++) begin
         @(negedge clk);
         if (cyc == 1) begin
            s_arid = ~id; s_araddr = $urandom; s_arlen = 8'($urandom); s_arburst = 2'($urandom);
         end
         checkOutput("ar_gated", s_arready, 1'b0);
         if (mem_rd_en) begin
            if (firstIssue < 0) firstIssue = cyc;
            if (issued < nBeats)
               checkOutput($sformatf("rd_addr[%0d]", issued), 64'(mem_rd_addr), 64'(expAddr[issued]));
            else
               checkOutput("extra_issue", mem_rd_en, 1'b0);
            issued++;
         end
         if (issued - accepted > maxOut) maxOut = issued - accepted;
         if (s_rvalid && firstValid < 0) firstValid = cyc;
         if (stalled) begin
            checkOutput("hold_valid", s_rvalid, 1'b1);
            checkOutput("hold_data", s_rdata, heldData);
         end
         if (firstValid >= 0 && (cyc - firstValid) < stallCycles)
            ready = 1'b0;
         else
            ready = randReady ? ($urandom_range(3) != 0) : 1'b1;
         s_rready = ready;
         if (s_rvalid && ready) begin
            if (accepted < nBeats) begin
               checkOutput($sformatf("rdata[%0d]", accepted), s_rdata, memArr[expAddr[accepted]]);
               checkOutput($sformatf("rlast[%0d]", accepted), s_rlast, (accepted == nBeats - 1));
               checkOutput($sformatf("rresp[%0d]", accepted), s_rresp, (burst == 2'b11) ? 2'b10 : 2'b00);
               checkOutput($sformatf("rid[%0d]", accepted), s_rid, id);
            end else
               checkOutput("extra_beat", s_rvalid, 1'b0);
            accepted++;
            done = (accepted >= nBeats);
         end
         stalled  = s_rvalid && !ready;
         heldData = s_rdata;
      end

      checkOutput("burst_done", done, 1'b1);
      checkOutput("first_issue_cycle", 64'(firstIssue), 64'd1);
      checkOutput("first_rvalid_cycle", 64'(firstValid), 64'd3);
      checkOutput("outstanding_le4", (maxOut <= 4), 1'b1);
      if (stallCycles > 0)
         checkOutput("stall_fill", 64'(maxOut), 64'd4);
      @(negedge clk);
      checkOutput("ar_reopen", s_arready, 1'b1);
      checkOutput("rvalid_after_last", s_rvalid, 1'b0);
      checkOutput("rd_en_after_last", mem_rd_en, 1'b0);
      checkOutput("issue_total", 64'(issued), 64'(nBeats));
      s_arvalid = 1'b0;
      s_rready  = 1'b0;
   endtask

   initial begin
      logic [7:0] rLen;
      logic [1:0] rBurst;
      for (int i = 0; i < DEPTH; i++) memArr[i] = $urandom;
      memVldQ = 1'b0; strayVld = 1'b0;
      s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = 3'b010; s_arburst = 2'b01;
      s_arvalid = 1'b0; s_rready = 1'b0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1 checkOutput("reset_outputs", allOutputs(), 64'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("reset_arready", s_arready, 1'b1);

      $display("[TB] single beat");
      applyStimulus(4'h3, 32'h40, 8'd0, 2'b01, 0, 1'b0);
      $display("[TB] INCR 8 beats");
      applyStimulus(4'h5, 32'h0, 8'd7, 2'b01, 0, 1'b0);
      $display("[TB] backpressure 16 beats");
      applyStimulus(4'h9, 32'h200, 8'd15, 2'b01, 10, 1'b0);
      $display("[TB] WRAP 4");
      applyStimulus(4'h1, 32'h38, 8'd3, 2'b10, 0, 1'b0);
      $display("[TB] FIXED");
      applyStimulus(4'h2, 32'h14, 8'd3, 2'b00, 0, 1'b0);
      $display("[TB] INCR across top word");
      applyStimulus(4'h6, 32'hFF8, 8'd3, 2'b01, 0, 1'b0);
      $display("[TB] reserved burst");
      applyStimulus(4'hC, 32'h100, 8'd5, 2'b11, 0, 1'b0);
      $display("[TB] WRAP with illegal length");
      applyStimulus(4'h7, 32'h3F0, 8'd5, 2'b10, 0, 1'b0);
      $display("[TB] WRAP 16");
      applyStimulus(4'hA, 32'hFD4, 8'd15, 2'b10, 0, 1'b1);

      $display("[TB] reset mid-burst");
      s_arid = 4'h4; s_araddr = 32'h80; s_arlen = 8'd7; s_arburst = 2'b01;
      s_arvalid = 1'b1; s_rready = 1'b1;
      @(negedge clk);
      s_arvalid = 1'b0;
      repeat (4) @(negedge clk);
      checkOutput("pre_reset_rvalid", s_rvalid, 1'b1);
      #2 rst_n = 1'b0;
      #1 checkOutput("midburst_reset_outputs", allOutputs(), 64'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      strayVld = 1'b1;
      @(negedge clk);
      checkOutput("post_reset_arready", s_arready, 1'b1);
      for (int c = 0; c < 8; c++) begin
         if (c == 2) strayVld = 1'b0;
         checkOutput($sformatf("no_stray_rvalid[%0d]", c), s_rvalid, 1'b0);
         checkOutput($sformatf("no_stray_rd_en[%0d]", c), mem_rd_en, 1'b0);
         @(negedge clk);
      end
      strayVld = 1'b0;
      applyStimulus(4'hB, 32'h44, 8'd2, 2'b01, 0, 1'b0);

      $display("[TB] randomized bursts");
      for (int n = 0; n < 12; n++) begin
         rBurst = 2'($urandom_range(3));
         if (rBurst == 2'b10 && $urandom_range(1) == 1)
            rLen = 8'((1 << $urandom_range(1, 4)) - 1);
         else
            rLen = 8'($urandom_range(20));
         applyStimulus(4'($urandom), $urandom, rLen, rBurst, 0, 1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule

// File: doc/axi_rd_burst_ctrl.md
Name: axi_rd_burst_ctrl

Overview:
- AXI4-full slave read-channel engine sitting directly upstream of the single-port-read logic memory.
- Accepts one AR burst at a time and generates per-beat memory read strobes/word addresses.
- Captures memory read data (1-cycle latency, qualified by the memory's valid flag) into a 4-entry output buffer and returns it on the R channel with RLAST and RRESP.
- Sustains one beat per clock while RREADY is high; absorbs RREADY backpressure without losing data.

Parameters:
- AXI_ADDR_WIDTH, 32, AXI byte-address width.
- MEM_ADDR_WIDTH, 10, memory word-address width (memory depth 2^MEM_ADDR_WIDTH).
- DATA_WIDTH, 32, data width; bytes per beat = DATA_WIDTH/8.
- ID_WIDTH, 4, AXI ID width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- s_arid  in  ID_WIDTH  burst ID.
- s_araddr  in  AXI_ADDR_WIDTH  start byte address.
- s_arlen  in  8  beats minus 1.
- s_arsize  in  3  beat size (ignored, full width assumed).
- s_arburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
- s_arvalid  in  1  AR valid.
- s_arready  out  1  AR ready.
- s_rid  out  ID_WIDTH  returned ID.
- s_rdata  out  DATA_WIDTH  read data.
- s_rresp  out  2  response, 00 OKAY / 10 SLVERR.
- s_rlast  out  1  final beat.
- s_rvalid  out  1  R valid.
- s_rready  in  1  R ready.
- mem_rd_en  out  1  memory read strobe.
- mem_rd_addr  out  MEM_ADDR_WIDTH  memory word address.
- mem_rd_dat_vld  in  1  memory data valid, one cycle after mem_rd_en.
- mem_rd_dat  in  DATA_WIDTH  memory read data.

Behaviour:
- Reset:
  - rst_n is asynchronous, active-low; clock is clk.
  - All outputs are 0, including s_arready.
  - FSM returns to IDLE; buffer is emptied; beat counters are cleared.
  - A reset mid-burst abandons the burst. No further R beats are produced, and any mem_rd_dat_vld arriving after reset release is ignored until a new AR handshake occurs.
- FSM states:
  - IDLE: s_arready = 1. On s_arvalid & s_arready, latch ID, len, and burst type. Latch word address = s_araddr[log2(DATA_WIDTH/8) +: MEM_ADDR_WIDTH]. Go to ISSUE.
  - ISSUE: s_arready = 0. Assert mem_rd_en for one cycle per beat when credit is available. After issuing beat arlen, go to DRAIN.
  - DRAIN: wait until the beat with s_rlast is accepted (s_rvalid & s_rready & s_rlast), then go to IDLE. s_arready rises the cycle after that acceptance.
- Only one burst is outstanding; a new AR is never accepted before the previous RLAST handshake.
- Credit rule:
  - Issue only if buffer_count + mem_rd_dat_vld < 4.
  - A buffer pop in the same cycle does not add credit until the next cycle.
- Buffer: 4-entry FIFO of {data, last, resp}.
  - Push on mem_rd_dat_vld.
  - Pop on s_rvalid & s_rready.
  - Simultaneous push and pop leave the count unchanged.
  - s_rvalid = (count != 0).
  - s_rdata, s_rlast, and s_rresp come from the head entry and stay stable while s_rvalid & !s_rready.
  - mem_rd_dat_vld is never ignored during a burst; overflow is impossible by the credit rule.
- Latency:
  - AR handshake at edge T; first mem_rd_en during cycle T+1; mem_rd_dat_vld during T+2; s_rvalid during T+3.
  - With s_rready held high, beats follow back-to-back (one per cycle).
- Address generation, per issued beat:
  - FIXED: address constant.
  - INCR: +1, wraps modulo 2^MEM_ADDR_WIDTH.
  - WRAP: +1 within an aligned block of (arlen+1) words. Boundary = addr & ~arlen. Legal arlen is 1, 3, 7, or 15; other arlen values are treated as INCR.
  - Reserved burst 11: treated as INCR, and every beat has s_rresp = 10 (SLVERR). Otherwise s_rresp = 00.
- Last flag: tagged on the beat whose issue index equals the latched arlen. arlen = 0 gives a single beat with s_rlast = 1.
- s_rid holds the latched ID for every beat of the burst.

Test Plan:
- Single beat: araddr=0x40, arlen=0, INCR, rready=1 -> mem_rd_addr=0x10 for one cycle; one R beat with rlast=1, rresp=00, rid=arid, rvalid 3 cycles after the AR handshake.
- INCR 8 beats: araddr=0x0, arlen=7, rready=1 -> mem_rd_addr 0..7 on consecutive cycles; 8 back-to-back R beats with data matching memory; rlast only on beat 7.
- Backpressure: arlen=15, rready low for 10 cycles after the first rvalid -> issue stalls with at most 4 buffered beats; s_rdata is stable while stalled; all 16 beats delivered in order with no loss or duplication.
- WRAP 4: araddr=0x38 (word 14), arlen=3 -> mem_rd_addr sequence 14, 15, 12, 13.
- FIXED and edge cases:
  - FIXED: arlen=3 at word 5 -> addr 5 four times.
  - INCR crossing the top word: start at word 1022, arlen=3 -> 1022, 1023, 0, 1.
  - arburst=11 -> every beat has rresp=10.
- Reset mid-burst and AR gating:
  - Assert rst_n low during beat 3 of 8 -> all outputs 0 immediately; after release, s_arready=1 and no stray R beats appear.
  - A second AR presented during a burst is held off until the cycle after the RLAST handshake.
